// File: rtl/grad_abs_pipe_if.sv
// Stream interface for the pipelined gradient absolute-value stage: gx/gy beats
// in, |gx|/|gy| plus orientation flags out, each side with a valid/ready handshake.
interface grad_abs_pipe_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1
) ();
  logic                               in_valid;
  logic                               in_ready;
  logic [CHANNELS*(DATA_WIDTH+1)-1:0] gx;
  logic [CHANNELS*(DATA_WIDTH+1)-1:0] gy;
  logic                               out_valid;
  logic                               out_ready;
  logic [CHANNELS*DATA_WIDTH-1:0]     abs_x;
  logic [CHANNELS*DATA_WIDTH-1:0]     abs_y;
  logic [CHANNELS-1:0]                is_upper_bin;
  logic [CHANNELS-1:0]                steep;
  logic [CHANNELS-1:0]                sat_flag;

  // Upstream filter and downstream binning stage drive this side.
  modport master (
    output in_valid, gx, gy, out_ready,
    input  in_ready, out_valid, abs_x, abs_y, is_upper_bin, steep, sat_flag
  );

  // The gradient absolute-value pipeline sits on this side.
  modport slave (
    input  in_valid, gx, gy, out_ready,
    output in_ready, out_valid, abs_x, abs_y, is_upper_bin, steep, sat_flag
  );
endinterface

// File: rtl/grad_abs_pipe.sv
// Two-stage gradient absolute-value pipeline: S1 takes signs, magnitudes and
// saturation, S2 derives the orientation flags and drives the outputs.
module grad_abs_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int SATURATE   = 1
) (
  input logic            clk,
  input logic            rst_n,
  grad_abs_pipe_if.slave bus
);
  localparam int IW = DATA_WIDTH + 1;
  localparam logic [IW-1:0] MOST_NEG = {1'b1, {DATA_WIDTH{1'b0}}};

  // The most-negative input has no positive counterpart in DATA_WIDTH bits.
  function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [IW-1:0] v);
    logic [IW-1:0] neg_s;
    neg_s = ~v + {{DATA_WIDTH{1'b0}}, 1'b1};
    if (!v[IW-1]) begin
      abs_sat = v[DATA_WIDTH-1:0];
    end else if (v == MOST_NEG) begin
      abs_sat = (SATURATE != 0) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    end else begin
      abs_sat = neg_s[DATA_WIDTH-1:0];
    end
  endfunction

  logic                           s1_en_s;
  logic                           s2_en_s;
  logic [CHANNELS*DATA_WIDTH-1:0] s1_ax_s;
  logic [CHANNELS*DATA_WIDTH-1:0] s1_ay_s;
  logic [CHANNELS-1:0]            s1_sx_s;
  logic [CHANNELS-1:0]            s1_sy_s;
  logic [CHANNELS-1:0]            s1_sat_s;
  logic [CHANNELS-1:0]            s2_upper_s;
  logic [CHANNELS-1:0]            s2_steep_s;

  logic                           s1_valid_r;
  logic [CHANNELS*DATA_WIDTH-1:0] s1_ax_r;
  logic [CHANNELS*DATA_WIDTH-1:0] s1_ay_r;
  logic [CHANNELS-1:0]            s1_sx_r;
  logic [CHANNELS-1:0]            s1_sy_r;
  logic [CHANNELS-1:0]            s1_sat_r;

  logic                           s2_valid_r;
  logic [CHANNELS*DATA_WIDTH-1:0] s2_ax_r;
  logic [CHANNELS*DATA_WIDTH-1:0] s2_ay_r;
  logic [CHANNELS-1:0]            s2_upper_r;
  logic [CHANNELS-1:0]            s2_steep_r;
  logic [CHANNELS-1:0]            s2_sat_r;

  // A stage may advance when it is empty or the stage after it is advancing.
  assign s2_en_s      = !s2_valid_r || bus.out_ready;
  assign s1_en_s      = !s1_valid_r || s2_en_s;
  assign bus.in_ready = s1_en_s;

  // Per-channel sign, magnitude and saturation detect on the incoming beat.
  always_comb begin
    s1_ax_s  = {(CHANNELS*DATA_WIDTH){1'b0}};
    s1_ay_s  = {(CHANNELS*DATA_WIDTH){1'b0}};
    s1_sx_s  = {CHANNELS{1'b0}};
    s1_sy_s  = {CHANNELS{1'b0}};
    s1_sat_s = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      s1_ax_s[c*DATA_WIDTH +: DATA_WIDTH] = abs_sat(bus.gx[c*IW +: IW]);
      s1_ay_s[c*DATA_WIDTH +: DATA_WIDTH] = abs_sat(bus.gy[c*IW +: IW]);
      s1_sx_s[c]  = bus.gx[c*IW + IW - 1];
      s1_sy_s[c]  = bus.gy[c*IW + IW - 1];
      s1_sat_s[c] = (bus.gx[c*IW +: IW] == MOST_NEG) || (bus.gy[c*IW +: IW] == MOST_NEG);
    end
  end

  // Orientation flags from the S1 registers; zero counts as positive.
  always_comb begin
    s2_upper_s = s1_sx_r ^ s1_sy_r;
    s2_steep_s = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      s2_steep_s[c] = s1_ay_r[c*DATA_WIDTH +: DATA_WIDTH] > s1_ax_r[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_ax_r    <= {(CHANNELS*DATA_WIDTH){1'b0}};
      s1_ay_r    <= {(CHANNELS*DATA_WIDTH){1'b0}};
      s1_sx_r    <= {CHANNELS{1'b0}};
      s1_sy_r    <= {CHANNELS{1'b0}};
      s1_sat_r   <= {CHANNELS{1'b0}};
    end else if (s1_en_s) begin
      s1_valid_r <= bus.in_valid;
      s1_ax_r    <= s1_ax_s;
      s1_ay_r    <= s1_ay_s;
      s1_sx_r    <= s1_sx_s;
      s1_sy_r    <= s1_sy_s;
      s1_sat_r   <= s1_sat_s;
    end
  end

  // Stage 2 registers, which drive the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_ax_r    <= {(CHANNELS*DATA_WIDTH){1'b0}};
      s2_ay_r    <= {(CHANNELS*DATA_WIDTH){1'b0}};
      s2_upper_r <= {CHANNELS{1'b0}};
      s2_steep_r <= {CHANNELS{1'b0}};
      s2_sat_r   <= {CHANNELS{1'b0}};
    end else if (s2_en_s) begin
      s2_valid_r <= s1_valid_r;
      s2_ax_r    <= s1_ax_r;
      s2_ay_r    <= s1_ay_r;
      s2_upper_r <= s2_upper_s;
      s2_steep_r <= s2_steep_s;
      s2_sat_r   <= s1_sat_r;
    end
  end

  assign bus.out_valid    = s2_valid_r;
  assign bus.abs_x        = s2_ax_r;
  assign bus.abs_y        = s2_ay_r;
  assign bus.is_upper_bin = s2_upper_r;
  assign bus.steep        = s2_steep_r;
  assign bus.sat_flag     = s2_sat_r;
endmodule

// File: tb/tb_grad_abs_pipe.sv
// Scoreboard bench for grad_abs_pipe: a 4-channel saturating instance and a
// 1-channel wrapping instance, checked against an integer reference model.
module tb_grad_abs_pipe;
  localparam int DW = 8;
  localparam int CH = 4;

  typedef struct packed {
    logic [CH*DW-1:0] ax;
    logic [CH*DW-1:0] ay;
    logic [CH-1:0]    up;
    logic [CH-1:0]    st;
    logic [CH-1:0]    sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  grad_abs_pipe_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus_a ();
  grad_abs_pipe_if #(.DATA_WIDTH(DW), .CHANNELS(1))  bus_b ();

  grad_abs_pipe #(.DATA_WIDTH(DW), .CHANNELS(CH), .SATURATE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  grad_abs_pipe #(.DATA_WIDTH(DW), .CHANNELS(1), .SATURATE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   gxv[CH];
  int   gyv[CH];

  function automatic logic [7:0] m_abs(input int v, input bit sat);
    if (v == -256) return sat ? 8'd255 : 8'd0;
    return (v < 0) ? 8'(-v) : 8'(v);
  endfunction

  function automatic exp_t model_a();
    exp_t e;
    logic [7:0] ax, ay;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      ax = m_abs(gxv[c], 1'b1);
      ay = m_abs(gyv[c], 1'b1);
      e.ax[c*DW +: DW] = ax;
      e.ay[c*DW +: DW] = ay;
      e.up[c]  = (gxv[c] < 0) != (gyv[c] < 0);
      e.st[c]  = ay > ax;
      e.sat[c] = (gxv[c] == -256) || (gyv[c] == -256);
    end
    return e;
  endfunction

  function automatic exp_t obs_a();
    exp_t e;
    e.ax = bus_a.abs_x;  e.ay = bus_a.abs_y;
    e.up = bus_a.is_upper_bin;  e.st = bus_a.steep;  e.sat = bus_a.sat_flag;
    return e;
  endfunction

  task automatic load_a();
    for (int c = 0; c < CH; c++) begin
      bus_a.gx[c*9 +: 9] = 9'(gxv[c]);
      bus_a.gy[c*9 +: 9] = 9'(gyv[c]);
    end
  endtask

  task automatic test_reset();
    exp_t o;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus_a.in_valid = 1'($urandom()); bus_a.out_ready = 1'($urandom());
      bus_a.gx = 36'({$urandom(), $urandom()}); bus_a.gy = 36'({$urandom(), $urandom()});
      bus_b.in_valid = 1'($urandom()); bus_b.gx = 9'($urandom()); bus_b.gy = 9'($urandom());
    end
    @(negedge clk);
    o = obs_a();
    checks++;
    if (bus_a.out_valid !== 1'b0 || o !== '0) begin
      errors++; $display("FAIL reset_hold: out_valid=%b outs=%h want 0", bus_a.out_valid, o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
    @(negedge clk);
    o = obs_a();
    checks++;
    if (bus_a.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus_a.in_ready);
    end
    checks++;
    if (bus_a.out_valid !== 1'b0 || o !== '0) begin
      errors++; $display("FAIL reset_idle: out_valid=%b outs=%h want 0", bus_a.out_valid, o);
    end
    checks++;
    if (bus_b.out_valid !== 1'b0 || bus_b.abs_x !== 8'd0 || bus_b.sat_flag !== 1'b0) begin
      errors++; $display("FAIL reset_b: out_valid=%b abs_x=%h sat=%b want 0", bus_b.out_valid, bus_b.abs_x, bus_b.sat_flag);
    end
  endtask

  task automatic test_latency();
    exp_t e, o;
    gxv = '{-5, 0, 9, 3};
    gyv = '{12, -7, -9, 4};
    @(posedge clk); #1;
    bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b1; load_a();
    @(negedge clk);
    checks++;
    if (bus_a.in_ready !== 1'b1) begin
      errors++; $display("FAIL lat_in_ready: got %b want 1", bus_a.in_ready);
    end
    sb.push_back(model_a());
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.out_valid !== 1'b0) begin
      errors++; $display("FAIL lat_early: out_valid=%b want 0 after 1 cycle", bus_a.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus_a.out_valid !== 1'b1) begin
      errors++; $display("FAIL lat_valid: out_valid=%b want 1 after 2 cycles", bus_a.out_valid);
    end
    e = sb.pop_front();
    o = obs_a();
    checks++;
    if (o !== e) begin
      errors++; $display("FAIL lat_data: got %h want %h", o, e);
    end
    checks++;
    if (bus_a.abs_x[7:0] !== 8'd5 || bus_a.abs_y[7:0] !== 8'd12 || bus_a.is_upper_bin[0] !== 1'b1 ||
        bus_a.steep[0] !== 1'b1 || bus_a.sat_flag[0] !== 1'b0) begin
      errors++; $display("FAIL lat_ch0: ax=%0d ay=%0d up=%b st=%b sat=%b want 5 12 1 1 0",
        bus_a.abs_x[7:0], bus_a.abs_y[7:0], bus_a.is_upper_bin[0], bus_a.steep[0], bus_a.sat_flag[0]);
    end
    checks++;
    if (bus_a.abs_x[15:8] !== 8'd0 || bus_a.abs_y[15:8] !== 8'd7 || bus_a.is_upper_bin[1] !== 1'b1 ||
        bus_a.steep[1] !== 1'b1 || bus_a.steep[2] !== 1'b0 || bus_a.is_upper_bin[2] !== 1'b1) begin
      errors++; $display("FAIL lat_edges: ax1=%0d ay1=%0d up=%b st=%b want 0 7 up=x11x st=x01x",
        bus_a.abs_x[15:8], bus_a.abs_y[15:8], bus_a.is_upper_bin, bus_a.steep);
    end
    @(negedge clk);
    checks++;
    if (bus_a.out_valid !== 1'b0) begin
      errors++; $display("FAIL lat_pulse: out_valid=%b want 0 after one beat", bus_a.out_valid);
    end
  endtask

  task automatic test_saturation();
    exp_t e, o;
    gxv = '{-256, -256, 255, -255};
    gyv = '{-256, 7, -256, 255};
    @(posedge clk); #1;
    bus_a.in_valid = 1'b1; load_a();
    bus_b.in_valid = 1'b1; bus_b.gx = 9'h100; bus_b.gy = 9'h100;
    @(negedge clk);
    sb.push_back(model_a());
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    bus_b.gx = 9'h1FB; bus_b.gy = 9'd12;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    o = obs_a();
    checks++;
    if (bus_a.out_valid !== 1'b1 || o !== e) begin
      errors++; $display("FAIL sat_a: valid=%b got %h want %h", bus_a.out_valid, o, e);
    end
    checks++;
    if (bus_a.abs_x[7:0] !== 8'd255 || bus_a.abs_y[7:0] !== 8'd255 || bus_a.sat_flag[0] !== 1'b1 ||
        bus_a.is_upper_bin[0] !== 1'b0 || bus_a.steep[0] !== 1'b0) begin
      errors++; $display("FAIL sat_a_ch0: ax=%0d ay=%0d sat=%b up=%b st=%b want 255 255 1 0 0",
        bus_a.abs_x[7:0], bus_a.abs_y[7:0], bus_a.sat_flag[0], bus_a.is_upper_bin[0], bus_a.steep[0]);
    end
    checks++;
    if (bus_b.out_valid !== 1'b1 || bus_b.abs_x !== 8'd0 || bus_b.abs_y !== 8'd0 || bus_b.sat_flag !== 1'b1) begin
      errors++; $display("FAIL sat_wrap: valid=%b ax=%0d ay=%0d sat=%b want 1 0 0 1",
        bus_b.out_valid, bus_b.abs_x, bus_b.abs_y, bus_b.sat_flag);
    end
    @(negedge clk);
    checks++;
    if (bus_b.out_valid !== 1'b1 || bus_b.abs_x !== 8'd5 || bus_b.abs_y !== 8'd12 ||
        bus_b.is_upper_bin !== 1'b1 || bus_b.steep !== 1'b1 || bus_b.sat_flag !== 1'b0) begin
      errors++; $display("FAIL wrap_normal: ax=%0d ay=%0d up=%b st=%b sat=%b want 5 12 1 1 0",
        bus_b.abs_x, bus_b.abs_y, bus_b.is_upper_bin, bus_b.steep, bus_b.sat_flag);
    end
  endtask

  task automatic test_backpressure();
    exp_t e, o, held;
    bit   held_ok = 1'b0;
    bit   accepted = 1'b1;
    int   sent = 0;
    int   received = 0;
    int   cyc = 0;
    void'($urandom(32'd20240611));
    sb.delete();
    while (received < 20 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (accepted && sent < 20) begin
        for (int c = 0; c < CH; c++) begin
          gxv[c] = int'($urandom_range(511)) - 256;
          gyv[c] = int'($urandom_range(511)) - 256;
        end
        if (sent == 3) gxv[0] = -256;
        load_a();
      end
      bus_a.in_valid  = (sent < 20);
      bus_a.out_ready = 1'($urandom());
      @(negedge clk);
      o = obs_a();
      checks++;
      if (bus_a.in_ready !== !(sb.size() == 2 && !bus_a.out_ready)) begin
        errors++; $display("FAIL bp_in_ready: got %b want %b (occupancy %0d, out_ready %b)",
          bus_a.in_ready, !(sb.size() == 2 && !bus_a.out_ready), sb.size(), bus_a.out_ready);
      end
      if (held_ok) begin
        checks++;
        if (bus_a.out_valid !== 1'b1 || o !== held) begin
          errors++; $display("FAIL bp_stable: valid=%b got %h want held %h", bus_a.out_valid, o, held);
        end
      end
      held_ok = bus_a.out_valid && !bus_a.out_ready;
      held = o;
      if (bus_a.out_valid && bus_a.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_extra: unexpected beat %h, scoreboard empty", o);
        end else begin
          e = sb.pop_front();
          if (o !== e) begin
            errors++; $display("FAIL bp_data beat %0d: got %h want %h", received, o, e);
          end
        end
        received++;
      end
      accepted = bus_a.in_valid && bus_a.in_ready;
      if (accepted) begin
        sb.push_back(model_a());
        sent++;
      end
    end
    checks++;
    if (received != 20 || sb.size() != 0) begin
      errors++; $display("FAIL bp_count: received %0d want 20, leftover %0d want 0", received, sb.size());
    end
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_a.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_dup: out_valid=%b want 0 after drain", bus_a.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    bit   seen = 1'b0;
    sb.delete();
    bus_a.out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      gxv = '{b + 1, -3, 40, -100};
      gyv = '{-2, b + 6, -41, 100};
      bus_a.in_valid = 1'b1; load_a();
    end
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    o = obs_a();
    checks++;
    if (bus_a.out_valid !== 1'b0 || o !== '0) begin
      errors++; $display("FAIL rst_mid_drop: valid=%b outs=%h want 0", bus_a.out_valid, o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    gxv = '{-77, 8, 0, 200};
    gyv = '{33, -8, 0, -201};
    bus_a.in_valid = 1'b1; load_a();
    @(negedge clk);
    checks++;
    if (bus_a.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready: got %b want 1", bus_a.in_ready);
    end
    sb.push_back(model_a());
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (bus_a.out_valid) begin
        seen = 1'b1;
        e = sb.pop_front();
        o = obs_a();
        checks++;
        if (o !== e || i != 1) begin
          errors++; $display("FAIL rst_mid_first: got %h at cycle %0d want %h at cycle 1", o, i, e);
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL rst_mid_timeout: no output within 5 cycles after reset");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1; bus_a.gx = '0; bus_a.gy = '0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1; bus_b.gx = '0; bus_b.gy = '0;
    test_reset();
    test_latency();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
